// File: rtl/nrisc_busca_decod.sv
// Fetch/decode stage: owns the PC, fetches one byte per instruction, holds it for execute.
// Latency: memory latency + 1 cycle to instr_valido; backpressure holds the instruction until exec_pronto.
// Optional HALT opcode (4'hF) with stop state PARADO when NRISC_HALT_EN is defined.
module nrisc_busca_decod #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] PC_RESET = '0,
  parameter int              OPC_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             mem_req,
  output logic [PC_W-1:0]  mem_end,
  input  logic             mem_valido,
  input  logic [7:0]       mem_dado,
  output logic             instr_valido,
  input  logic             exec_pronto,
  output logic [OPC_W-1:0] opcode,
  output logic [1:0]       campo_ra,
  output logic [1:0]       campo_rb,
  output logic [3:0]       imediato,
  output logic [PC_W-1:0]  pc,
`ifdef NRISC_HALT_EN
  output logic             halt_flag,
`endif
  input  logic             desvio,
  input  logic [PC_W-1:0]  desvio_alvo
);

  typedef enum logic [1:0] {
    INICIO  = 2'd0,
    BUSCA   = 2'd1,
    ENTREGA = 2'd2,
    PARADO  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] instr_reg;
  logic       discard;

`ifdef NRISC_HALT_EN
  logic is_halt;
  assign is_halt = (instr_reg[7:4] == 4'hF);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INICIO;
    end else begin
      state <= state_nxt;
    end
  end

  // A branch overrides everything except the post-reset idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      INICIO: state_nxt = BUSCA;
      BUSCA: begin
        if (!desvio && mem_valido && !discard) begin
          state_nxt = ENTREGA;
        end
      end
      ENTREGA: begin
        if (desvio) begin
          state_nxt = BUSCA;
        end else if (exec_pronto) begin
`ifdef NRISC_HALT_EN
          state_nxt = is_halt ? PARADO : BUSCA;
`else
          state_nxt = BUSCA;
`endif
        end
      end
      PARADO: begin
        if (desvio) begin
          state_nxt = BUSCA;
        end
      end
      default: state_nxt = INICIO;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    instr_valido = 1'b0;
`ifdef NRISC_HALT_EN
    halt_flag    = 1'b0;
`endif
    case (state)
      BUSCA:   mem_req      = 1'b1;
      ENTREGA: instr_valido = 1'b1;
`ifdef NRISC_HALT_EN
      PARADO:  halt_flag    = 1'b1;
`endif
      default: ;
    endcase
  end

  // A branch taken while a request is still unanswered marks its response as stale.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= PC_RESET;
      instr_reg <= 8'h00;
      discard   <= 1'b0;
    end else begin
      case (state)
        BUSCA: begin
          if (desvio) begin
            pc      <= desvio_alvo;
            discard <= !mem_valido;
          end else if (mem_valido) begin
            if (discard) begin
              discard <= 1'b0;
            end else begin
              instr_reg <= mem_dado;
            end
          end
        end
        ENTREGA: begin
          if (desvio) begin
            pc <= desvio_alvo;
          end else if (exec_pronto) begin
`ifdef NRISC_HALT_EN
            if (!is_halt) begin
              pc <= pc + 1'b1;
            end
`else
            pc <= pc + 1'b1;
`endif
          end
        end
        PARADO: begin
          if (desvio) begin
            pc <= desvio_alvo;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_end  = pc;
  assign opcode   = instr_reg[7:8-OPC_W];
  assign campo_ra = instr_reg[3:2];
  assign campo_rb = instr_reg[1:0];
  assign imediato = instr_reg[3:0];

endmodule

// File: tb/tb_nrisc_busca_decod.sv
// Directed bench for nrisc_busca_decod: bench-side memory, expected instructions queued when served.
module tb_nrisc_busca_decod;

  logic       clock;
  logic       reset_n;
  logic       mem_req;
  logic [7:0] mem_end;
  logic       mem_valido;
  logic [7:0] mem_dado;
  logic       instr_valido;
  logic       exec_pronto;
  logic [3:0] opcode;
  logic [1:0] campo_ra;
  logic [1:0] campo_rb;
  logic [3:0] imediato;
  logic [7:0] pc;
  logic       desvio;
  logic [7:0] desvio_alvo;
`ifdef NRISC_HALT_EN
  logic       halt_flag;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [256];
  int         checks   = 0;
  int         failures = 0;

  nrisc_busca_decod dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mem_req      (mem_req),
    .mem_end      (mem_end),
    .mem_valido   (mem_valido),
    .mem_dado     (mem_dado),
    .instr_valido (instr_valido),
    .exec_pronto  (exec_pronto),
    .opcode       (opcode),
    .campo_ra     (campo_ra),
    .campo_rb     (campo_rb),
    .imediato     (imediato),
    .pc           (pc),
`ifdef NRISC_HALT_EN
    .halt_flag    (halt_flag),
`endif
    .desvio       (desvio),
    .desvio_alvo  (desvio_alvo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a request, then answers it after lat cycles; push=1 queues the byte as expected output.
  task automatic serve(input int lat, input bit push);
    int         n = 0;
    logic [7:0] addr;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_mem_req", 32'(mem_req), 32'h1);
    addr = mem_end;
    if (push) sb.push_back('{addr: addr, dat: mem[addr]});
    repeat (lat - 1) tick();
    mem_valido = 1'b1;
    mem_dado   = mem[addr];
    tick();
    mem_valido = 1'b0;
    mem_dado   = 8'hxx;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (instr_valido !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_instr_valido", 32'(instr_valido), 32'h1);
  endtask

  task automatic check_fields();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      chk("opcode",   32'(opcode),   32'(e.dat[7:4]));
      chk("campo_ra", 32'(campo_ra), 32'(e.dat[3:2]));
      chk("campo_rb", 32'(campo_rb), 32'(e.dat[1:0]));
      chk("imediato", 32'(imediato), 32'(e.dat[3:0]));
      chk("pc_deliver", 32'(pc), 32'(e.addr));
    end
  endtask

  task automatic accept(input logic [7:0] next_pc);
    wait_valid();
    check_fields();
    exec_pronto = 1'b1;
    tick();
    exec_pronto = 1'b0;
    chk("valid_after_accept", 32'(instr_valido), 32'h0);
    chk("pc_after_accept", 32'(pc), 32'(next_pc));
  endtask

  initial begin
    reset_n     = 1'b0;
    mem_valido  = 1'b0;
    mem_dado    = 8'hxx;
    exec_pronto = 1'b0;
    desvio      = 1'b0;
    desvio_alvo = 8'h00;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h00] = 8'h3A;
    mem[8'h01] = 8'h7E;
    mem[8'h02] = 8'hAA;
    mem[8'h40] = 8'h5C;
    mem[8'h41] = 8'h21;
    mem[8'h80] = 8'h66;
    mem[8'hFF] = 8'h9F;
    mem[8'h10] = 8'h12;

    // Reset and the idle cycle after release
    repeat (3) tick();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_instr_valido", 32'(instr_valido), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_imediato", 32'(imediato), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    chk("inicio_mem_req", 32'(mem_req), 32'h0);
    tick();
    chk("busca_mem_req", 32'(mem_req), 32'h1);
    chk("busca_mem_end", 32'(mem_end), 32'h00);

    // Sequential fetch, memory latency 2
    serve(2, 1'b1);
    chk("lat_instr_valido", 32'(instr_valido), 32'h1);
    chk("lat_mem_req_drop", 32'(mem_req), 32'h0);
    accept(8'h01);
    chk("refetch_mem_req", 32'(mem_req), 32'h1);

    // Backpressure: held 5 cycles, then exactly one transfer
    serve(1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(instr_valido), 32'h1);
      chk("hold_opcode", 32'(opcode), 32'h7);
      chk("hold_imediato", 32'(imediato), 32'hE);
      chk("hold_pc", 32'(pc), 32'h01);
      tick();
    end
    accept(8'h02);
    tick();
    chk("single_transfer_valid", 32'(instr_valido), 32'h0);
    chk("single_transfer_pc", 32'(pc), 32'h02);

    // Branch while a request is outstanding: the stale byte must vanish
    desvio      = 1'b1;
    desvio_alvo = 8'h40;
    tick();
    desvio = 1'b0;
    chk("branch_mem_end", 32'(mem_end), 32'h40);
    chk("branch_mem_req", 32'(mem_req), 32'h1);
    mem_valido = 1'b1;
    mem_dado   = mem[8'h02];
    tick();
    mem_valido = 1'b0;
    mem_dado   = 8'hxx;
    chk("stale_dropped_valid", 32'(instr_valido), 32'h0);
    chk("stale_dropped_req", 32'(mem_req), 32'h1);
    chk("stale_dropped_end", 32'(mem_end), 32'h40);
    serve(2, 1'b1);
    accept(8'h41);

    // Branch together with exec_pronto: branch wins, no increment
    serve(1, 1'b1);
    wait_valid();
    check_fields();
    exec_pronto = 1'b1;
    desvio      = 1'b1;
    desvio_alvo = 8'h80;
    tick();
    exec_pronto = 1'b0;
    desvio      = 1'b0;
    chk("br_accept_valid", 32'(instr_valido), 32'h0);
    chk("br_accept_pc", 32'(pc), 32'h80);
    chk("br_accept_req", 32'(mem_req), 32'h1);

    // Branch together with a response: byte dropped, no stale flag left behind
    mem_valido  = 1'b1;
    mem_dado    = mem[8'h80];
    desvio      = 1'b1;
    desvio_alvo = 8'hFF;
    tick();
    mem_valido = 1'b0;
    mem_dado   = 8'hxx;
    desvio     = 1'b0;
    chk("br_resp_valid", 32'(instr_valido), 32'h0);
    chk("br_resp_pc", 32'(pc), 32'hFF);
    serve(1, 1'b1);
    accept(8'h00);

    // Asynchronous reset in BUSCA with a stale flag pending
    desvio      = 1'b1;
    desvio_alvo = 8'h33;
    tick();
    desvio = 1'b0;
    chk("pre_reset_pc", 32'(pc), 32'h33);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'h00);
    chk("async_mem_req", 32'(mem_req), 32'h0);
    chk("async_opcode", 32'(opcode), 32'h0);
    chk("async_imediato", 32'(imediato), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    mem_valido = 1'b1;
    mem_dado   = 8'hEE;
    tick();
    chk("inicio2_mem_req", 32'(mem_req), 32'h0);
    tick();
    mem_valido = 1'b0;
    mem_dado   = 8'hxx;
    chk("inicio_resp_ignored", 32'(instr_valido), 32'h0);
    chk("post_reset_req", 32'(mem_req), 32'h1);
    chk("post_reset_end", 32'(mem_end), 32'h00);
    serve(1, 1'b1);
    accept(8'h01);

    // Opcode 4'hF
    mem[8'h01] = 8'hF0;
    serve(1, 1'b1);
`ifdef NRISC_HALT_EN
    wait_valid();
    chk("pre_halt_flag", 32'(halt_flag), 32'h0);
    accept(8'h01);
    chk("halt_flag", 32'(halt_flag), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_mem_req", 32'(mem_req), 32'h0);
      chk("halt_valid", 32'(instr_valido), 32'h0);
      chk("halt_pc", 32'(pc), 32'h01);
    end
    desvio      = 1'b1;
    desvio_alvo = 8'h10;
    tick();
    desvio = 1'b0;
    chk("resume_halt_flag", 32'(halt_flag), 32'h0);
    chk("resume_mem_req", 32'(mem_req), 32'h1);
    chk("resume_mem_end", 32'(mem_end), 32'h10);
    serve(1, 1'b1);
    accept(8'h11);
`else
    accept(8'h02);
    chk("f_ordinary_req", 32'(mem_req), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nrisc_busca_decod.md
Name: nrisc_busca_decod

Overview:
- Fetch/decode stage of the 8-bit nRISC core.
- Owns the PC and requests instruction bytes from instruction memory with a variable-latency handshake.
- Holds each fetched instruction in a register and presents its opcode, register fields and 4-bit immediate to execute. The immediate feeds the 4-to-8 zero extender directly downstream.
- Handles taken branches by redirecting the PC and squashing in-flight or held instructions.

Parameters:
- PC_W, 8, PC / instruction-address width.
- PC_RESET, 8'h00, PC value loaded on reset.
- OPC_W, 4, opcode width (instruction bits [7:4]); the operand field is the low 4 bits.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request; held high until accepted.
- mem_end  out  PC_W  fetch address (= pc).
- mem_valido  in  1  instruction byte valid this cycle.
- mem_dado  in  8  instruction byte.
- instr_valido  out  1  decoded instruction valid to execute.
- exec_pronto  in  1  execute accepts the instruction this cycle.
- opcode  out  OPC_W  instr[7:4].
- campo_ra  out  2  instr[3:2].
- campo_rb  out  2  instr[1:0].
- imediato  out  4  instr[3:0], to the zero extender.
- pc  out  PC_W  address of the current or next fetch.
- desvio  in  1  taken branch from execute.
- desvio_alvo  in  PC_W  branch target.

Behaviour:
- Reset (async, reset_n=0):
  - state=INICIO, pc=PC_RESET, mem_req=0, instr_valido=0.
  - Instruction register=8'h00, so opcode/campo_ra/campo_rb/imediato=0.
  - discard flag=0.
- States:
  - INICIO: one idle cycle after reset release, then BUSCA.
  - BUSCA: mem_req=1, mem_end=pc; wait for mem_valido.
  - ENTREGA: instr_valido=1; fields are driven from the instruction register and stay stable until accepted.
- BUSCA on mem_valido=1:
  - If discard=0: latch mem_dado into the instruction register and go to ENTREGA the next cycle.
  - If discard=1: drop the byte, clear discard, stay in BUSCA with pc unchanged.
  - mem_req deasserts in the cycle after mem_valido.
  - Latency from request to instr_valido is memory latency + 1 cycle.
- ENTREGA on exec_pronto=1 (transfer):
  - pc <= pc+1, wrapping modulo 2^PC_W (8'hFF -> 8'h00).
  - instr_valido=0 the next cycle; go to BUSCA.
- desvio=1 takes priority over every other event in any state except INICIO, where it is ignored:
  - pc <= desvio_alvo; instr_valido forced to 0 the next cycle; go to BUSCA.
  - If a request is outstanding in BUSCA without mem_valido this cycle, set discard=1 so the stale response is dropped.
  - desvio together with exec_pronto in ENTREGA: the branch wins. No pc+1; the held instruction is considered consumed.
  - desvio together with mem_valido in BUSCA: the byte is dropped; discard stays 0.
- No internal buffering beyond one instruction; throughput is at most one instruction per 2 cycles.
- mem_valido outside BUSCA is ignored.
- Reset mid-operation: all state is cleared immediately and asynchronously. Any outstanding memory response after reset release is ignored while in INICIO.
- mem_dado X while mem_valido=0 must not propagate to the outputs.

Optional Feature:
- Macro NRISC_HALT_EN.
- When defined:
  - Opcode 4'hF is HALT and adds state PARADO.
  - After HALT is accepted in ENTREGA (exec_pronto=1), go to PARADO instead of BUSCA.
  - pc does not increment; mem_req=0 and instr_valido=0 permanently.
  - Only reset_n or desvio leaves PARADO.
  - Output halt_flag (1 bit) is high in PARADO.
- When undefined:
  - 4'hF is an ordinary opcode passed through like any other; the halt_flag port does not exist.

Test Plan:
- Reset: reset_n=0 for 3 cycles, release -> pc=8'h00, mem_req=0 for one cycle, then mem_req=1 with mem_end=8'h00.
- Sequential fetch: memory returns 8'h3A after 2 cycles, exec_pronto=1 -> opcode=4'h3, campo_ra=2'b10, campo_rb=2'b10, imediato=4'hA; then pc=8'h01.
- Backpressure: instruction 8'h7E held with exec_pronto=0 for 5 cycles -> instr_valido and fields stable, pc stays; one-cycle exec_pronto -> exactly one transfer.
- Branch squash: desvio=1, desvio_alvo=8'h40 while a request is outstanding -> the stale response is dropped, the next mem_end=8'h40, and only the 8'h40 instruction is delivered. A second case applies desvio during ENTREGA with exec_pronto=1 -> no pc+1.
- Wrap and async reset: start at pc=8'hFF, accept one instruction -> pc=8'h00. Assert reset_n=0 mid-BUSCA -> outputs clear without waiting for a clock edge.
- NRISC_HALT_EN: fetch 8'hF0 and accept it -> halt_flag=1, mem_req stays 0 for 10 cycles; desvio to 8'h10 -> resumes fetching at 8'h10.
